// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares one 2R/1W register file (registered reads) between a core port (A)
// and a debug/DMA port (B). Round-robin grant, one request in flight, response pulse 3 cycles
// after the accept edge.
module regfile_arbiter #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    // port A (core)
    input  logic          a_valid,
    input  logic          a_we,
    input  logic [AW-1:0] a_ra1,
    input  logic [AW-1:0] a_ra2,
    input  logic [AW-1:0] a_wa,
    input  logic [DW-1:0] a_wd,
    output logic          a_ready,
    output logic          a_rsp_valid,
    // port B (debug/DMA)
    input  logic          b_valid,
    input  logic          b_we,
    input  logic [AW-1:0] b_ra1,
    input  logic [AW-1:0] b_ra2,
    input  logic [AW-1:0] b_wa,
    input  logic [DW-1:0] b_wd,
    output logic          b_ready,
    output logic          b_rsp_valid,
    // shared response
    output logic [DW-1:0] rsp_d1,
    output logic [DW-1:0] rsp_d2,
    output logic          busy,
    // register file side
    output logic [AW-1:0] rf_r1_addr,
    output logic [AW-1:0] rf_r2_addr,
    output logic [AW-1:0] rf_r3_addr,
    output logic [DW-1:0] rf_r3_in,
    output logic          rf_r3_we,
    input  logic [DW-1:0] rf_r1_out,
    input  logic [DW-1:0] rf_r2_out
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e        state_q, state_d;
    logic          grant_a, grant_b;
    logic          last_b_q;   // 1: last grant went to B (so a tie goes to A)
    logic          gnt_b_q;    // owner of the in-flight request
    logic          we_q;
    logic [AW-1:0] ra1_q, ra2_q, wa_q;
    logic [DW-1:0] wd_q;
    logic          rsp_a_q, rsp_b_q;
    logic [DW-1:0] rsp_d1_q, rsp_d2_q;

    // Next-state and round-robin grant; only IDLE can grant.
    always_comb begin
        state_d = state_q;
        grant_a = 1'b0;
        grant_b = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (a_valid && (!b_valid || last_b_q)) begin
                    grant_a = 1'b1;
                end else if (b_valid) begin
                    grant_b = 1'b1;
                end
                if (grant_a || grant_b) begin
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, arbitration history and latched request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            last_b_q <= 1'b1;
            gnt_b_q  <= 1'b0;
            we_q     <= 1'b0;
            ra1_q    <= '0;
            ra2_q    <= '0;
            wa_q     <= '0;
            wd_q     <= '0;
        end else begin
            state_q <= state_d;
            if (grant_a) begin
                last_b_q <= 1'b0;
                gnt_b_q  <= 1'b0;
                we_q     <= a_we;
                ra1_q    <= a_ra1;
                ra2_q    <= a_ra2;
                wa_q     <= a_wa;
                wd_q     <= a_wd;
            end else if (grant_b) begin
                last_b_q <= 1'b1;
                gnt_b_q  <= 1'b1;
                we_q     <= b_we;
                ra1_q    <= b_ra1;
                ra2_q    <= b_ra2;
                wa_q     <= b_wa;
                wd_q     <= b_wd;
            end
        end
    end

    // Capture regfile read data in RESP; pulse the owner's rsp_valid the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_a_q  <= 1'b0;
            rsp_b_q  <= 1'b0;
            rsp_d1_q <= '0;
            rsp_d2_q <= '0;
        end else begin
            rsp_a_q <= (state_q == StResp) && !gnt_b_q;
            rsp_b_q <= (state_q == StResp) && gnt_b_q;
            if (state_q == StResp) begin
                rsp_d1_q <= rf_r1_out;
                rsp_d2_q <= rf_r2_out;
            end
        end
    end

    // Output drive; ready is gated by rst_n so it is 0 throughout reset.
    always_comb begin
        a_ready     = rst_n & grant_a;
        b_ready     = rst_n & grant_b;
        a_rsp_valid = rsp_a_q;
        b_rsp_valid = rsp_b_q;
        rsp_d1      = rsp_d1_q;
        rsp_d2      = rsp_d2_q;
        busy        = (state_q != StIdle);
        rf_r1_addr  = ra1_q;
        rf_r2_addr  = ra2_q;
        rf_r3_addr  = wa_q;
        rf_r3_in    = wd_q;
        rf_r3_we    = (state_q == StIssue) && we_q;
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed scenarios plus random two-port traffic against a behavioural
// register-file model; a negedge monitor compares grants, regfile writes and responses.
module tb_regfile_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, a_we, b_valid, b_we;
    logic [AW-1:0] a_ra1, a_ra2, a_wa, b_ra1, b_ra2, b_wa;
    logic [DW-1:0] a_wd, b_wd;
    logic          a_ready, a_rsp_valid, b_ready, b_rsp_valid, busy;
    logic [DW-1:0] rsp_d1, rsp_d2;
    logic [AW-1:0] rf_r1_addr, rf_r2_addr, rf_r3_addr;
    logic [DW-1:0] rf_r3_in, rf_r1_out, rf_r2_out;
    logic          rf_r3_we;

    regfile_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_we(a_we), .a_ra1(a_ra1), .a_ra2(a_ra2), .a_wa(a_wa), .a_wd(a_wd),
        .a_ready(a_ready), .a_rsp_valid(a_rsp_valid),
        .b_valid(b_valid), .b_we(b_we), .b_ra1(b_ra1), .b_ra2(b_ra2), .b_wa(b_wa), .b_wd(b_wd),
        .b_ready(b_ready), .b_rsp_valid(b_rsp_valid),
        .rsp_d1(rsp_d1), .rsp_d2(rsp_d2), .busy(busy),
        .rf_r1_addr(rf_r1_addr), .rf_r2_addr(rf_r2_addr), .rf_r3_addr(rf_r3_addr),
        .rf_r3_in(rf_r3_in), .rf_r3_we(rf_r3_we), .rf_r1_out(rf_r1_out), .rf_r2_out(rf_r2_out)
    );

    always #5 clk = ~clk;

    // Physical register file: registered reads, read-before-write, not reset.
    logic [DW-1:0] rf_mem [32] = '{default: '0};
    always @(posedge clk) begin
        rf_r1_out <= rf_mem[rf_r1_addr];
        rf_r2_out <= rf_mem[rf_r2_addr];
        if (rf_r3_we) rf_mem[rf_r3_addr] <= rf_r3_in;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference model state
    typedef struct {
        logic          pb;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        int            cyc;
    } rsp_t;
    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] ra1, ra2, wa;
        logic [DW-1:0] wd;
    } iss_t;

    logic [DW-1:0] model_mem [32] = '{default: '0};
    rsp_t exp_q[$];
    iss_t iss;
    logic iss_valid = 1'b0;
    logic last_b = 1'b1;
    int   next_free = 0;
    logic t5_on = 1'b0;
    int   t5_n = 0;
    int   t5_last = 0;

    // Monitor: one request per 3 cycles, response 3 cycles after accept, write in cycle after.
    always @(negedge clk) begin
        logic idle, ga, gb, exp_we;
        rsp_t r;
        if (!rst_n) begin
            check("reset_outputs",
                  {a_ready, b_ready, a_rsp_valid, b_rsp_valid, busy, rf_r3_we, rsp_d1, rsp_d2,
                   rf_r1_addr, rf_r2_addr, rf_r3_addr, rf_r3_in}, '0);
            exp_q.delete();
            iss_valid = 1'b0;
            last_b    = 1'b1;
            next_free = 0;
        end else begin
            if (a_rsp_valid || b_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rsp", {a_rsp_valid, b_rsp_valid}, 2'b00);
                end else begin
                    r = exp_q.pop_front();
                    check("rsp_port", {a_rsp_valid, b_rsp_valid}, {!r.pb, r.pb});
                    check("rsp_cycle", cyc, r.cyc);
                    check("rsp_data", {rsp_d1, rsp_d2}, {r.d1, r.d2});
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                check("missing_rsp", 1'b0, 1'b1);
                exp_q.delete(0);
            end

            idle = (cyc >= next_free);
            check("busy", busy, !idle);
            ga = idle && a_valid && (!b_valid || last_b);
            gb = idle && b_valid && !ga;
            check("ready", {a_ready, b_ready}, {ga, gb});

            exp_we = iss_valid && (iss.cyc == cyc) && iss.we;
            check("rf_we", rf_r3_we, exp_we);
            if (iss_valid && iss.cyc == cyc) begin
                check("rf_ports", {rf_r1_addr, rf_r2_addr, rf_r3_addr, rf_r3_in},
                      {iss.ra1, iss.ra2, iss.wa, iss.wd});
                if (iss.we) model_mem[iss.wa] = iss.wd;
                iss_valid = 1'b0;
            end

            if (t5_on && (a_ready || b_ready)) begin
                check("t5_order", {a_ready, b_ready}, (t5_n % 2 == 0) ? 2'b10 : 2'b01);
                if (t5_n > 0) check("t5_spacing", cyc - t5_last, 3);
                t5_last = cyc;
                t5_n++;
            end

            if (ga || gb) begin
                iss.cyc = cyc + 1;
                iss.we  = ga ? a_we : b_we;
                iss.ra1 = ga ? a_ra1 : b_ra1;
                iss.ra2 = ga ? a_ra2 : b_ra2;
                iss.wa  = ga ? a_wa : b_wa;
                iss.wd  = ga ? a_wd : b_wd;
                iss_valid = 1'b1;
                r.pb  = gb;
                r.d1  = model_mem[iss.ra1];
                r.d2  = model_mem[iss.ra2];
                r.cyc = cyc + 3;
                exp_q.push_back(r);
                last_b    = gb;
                next_free = cyc + 3;
            end
        end
    end

    task automatic set_port(input logic pb, input logic v, input logic we,
                            input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                            input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        if (pb) begin
            b_valid = v; b_we = we; b_ra1 = ra1; b_ra2 = ra2; b_wa = wa; b_wd = wd;
        end else begin
            a_valid = v; a_we = we; a_ra1 = ra1; a_ra2 = ra2; a_wa = wa; a_wd = wd;
        end
    endtask

    // Issue one request, hold until accepted, then idle until its response has gone.
    task automatic req(input logic pb, input logic we, input logic [AW-1:0] ra1,
                       input logic [AW-1:0] ra2, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd);
        bit got = 0;
        @(posedge clk); #1;
        set_port(pb, 1'b1, we, ra1, ra2, wa, wd);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = pb ? b_ready : a_ready;
        end
        if (!got) check("req_accept_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        set_port(pb, 1'b0, 1'b0, '0, '0, '0, '0);
        repeat (4) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Random requester: after acceptance (or while idle) pick a new request or go quiet.
    task automatic drive(input logic pb, input int ncyc);
        logic acc;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            acc = pb ? (b_valid && b_ready) : (a_valid && a_ready);
            @(posedge clk); #1;
            if (acc || !(pb ? b_valid : a_valid)) begin
                if ($urandom_range(0, 2) != 0)
                    set_port(pb, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
                else
                    set_port(pb, 1'b0, 1'b0, '0, '0, '0, '0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        req(1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'hDEADBEEF);   // A writes reg 3
        req(1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 32'h0);          // B reads 3 and 0
        req(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 32'd7);          // write+read same reg
        req(1'b0, 1'b0, 5'd5, 5'd3, 5'd0, 32'h0);          // sees the written value

        // Contention straight out of reset: tie goes to A first.
        do_reset();
        @(posedge clk); #1;
        t5_on = 1'b1;
        set_port(1'b0, 1'b1, 1'b0, 5'd3, 5'd5, 5'd0, 32'h0);
        set_port(1'b1, 1'b1, 1'b0, 5'd5, 5'd3, 5'd0, 32'h0);
        for (int i = 0; i < 40 && t5_n < 6; i++) begin
            @(posedge clk); #1;
        end
        set_port(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        t5_on = 1'b0;
        check("t5_grants", t5_n, 6);
        repeat (5) @(posedge clk);

        // Reset while the write to reg 9 is in ISSUE: no pulse, no write.
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd9, 32'd1);
        begin
            bit got = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = a_ready;
            end
            if (!got) check("t6_accept_timeout", 1'b0, 1'b1);
        end
        @(posedge clk); #1;
        set_port(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        req(1'b1, 1'b0, 5'd9, 5'd3, 5'd0, 32'h0);

        // Random two-port traffic.
        fork
            drive(1'b0, 600);
            drive(1'b1, 600);
        join
        @(posedge clk); #1;
        set_port(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        repeat (8) @(posedge clk);
        check("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
